// File: rtl/matriz_loader.sv
// matriz_loader: serial-to-packed matrix writer feeding ula_determinante.
// Signed ELEM_W-bit elements arrive one per handshake in row-major order and
// are shifted into the packed matriz bus. The first element therefore ends up
// at the MSB of the used region, and the unused upper bits stay zero. The
// completed frame is held stable with matriz_valid until matriz_ack.
//
// Optional build macro: MATRIZ_TIMEOUT_EN. When it is defined, a LOAD that
// goes TIMEOUT_CYCLES cycles without a transfer is dropped back to IDLE.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   load_start        start a new frame (IDLE) or restart one (LOAD); samples tamanho_in
//   tamanho_in        size code 00=2x2 01=3x3 10=4x4 11=5x5
//   elem_in/valid     element stream, transfer on elem_valid & elem_ready
//   elem_ready        high in LOAD
//   matriz            packed frame, ELEM_W*MAX_DIM*MAX_DIM bits
//   tamanho_matriz    size code latched for the current frame
//   matriz_valid      high in HOLD
//   matriz_ack        consumer accepted the frame
//   busy              high in LOAD or HOLD
//   elem_count        elements accepted in the current frame
//   timeout_flag      one-cycle pulse on load timeout (0 without the macro)
//
// state | meaning
// IDLE  | no frame in progress; matriz keeps the last frame
// LOAD  | accepting elements until N have been transferred
// HOLD  | frame complete, presented until matriz_ack
module matriz_loader #(
    parameter int ELEM_W         = 8,
    parameter int MAX_DIM        = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_start,
    input  logic [1:0]                        tamanho_in,
    input  logic [ELEM_W-1:0]                 elem_in,
    input  logic                              elem_valid,
    output logic                              elem_ready,
    output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] matriz,
    output logic [1:0]                        tamanho_matriz,
    output logic                              matriz_valid,
    input  logic                              matriz_ack,
    output logic                              busy,
    output logic [4:0]                        elem_count,
    output logic                              timeout_flag
);

    localparam int MW = ELEM_W * MAX_DIM * MAX_DIM;

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("matriz_loader: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_next;
    logic   clear_frame;
    logic   transfer;
    logic [4:0] last_idx;

    // Index of the final element (N-1) for the latched size code.
    always_comb begin
        last_idx = 5'd3;
        case (tamanho_matriz)
            2'b00: last_idx = 5'd3;
            2'b01: last_idx = 5'd8;
            2'b10: last_idx = 5'd15;
            2'b11: last_idx = 5'd24;
            default: last_idx = 5'd3;
        endcase
    end

`ifdef MATRIZ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
`endif

    always_comb begin
        state_next  = state;
        clear_frame = 1'b0;
        transfer    = 1'b0;
`ifdef MATRIZ_TIMEOUT_EN
        tmo_hit     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (load_start) begin
                    clear_frame = 1'b1;
                    state_next  = LOAD;
                end
            end
            LOAD: begin
                // A restart takes priority; the element offered in that cycle is dropped.
                if (load_start) begin
                    clear_frame = 1'b1;
                end else if (elem_valid) begin
                    transfer = 1'b1;
                    if (elem_count == last_idx) state_next = HOLD;
                end
`ifdef MATRIZ_TIMEOUT_EN
                else if (tmo_cnt == '0) begin
                    tmo_hit    = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            HOLD: begin
                if (matriz_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            matriz         <= '0;
            tamanho_matriz <= 2'b00;
            elem_count     <= 5'd0;
        end else begin
            state <= state_next;
            if (clear_frame) begin
                matriz         <= '0;
                tamanho_matriz <= tamanho_in;
                elem_count     <= 5'd0;
            end else if (transfer) begin
                matriz     <= {matriz[MW-ELEM_W-1:0], elem_in};
                elem_count <= elem_count + 5'd1;
            end
`ifdef MATRIZ_TIMEOUT_EN
            else if (tmo_hit) begin
                matriz     <= '0;
                elem_count <= 5'd0;
            end
`endif
        end
    end

`ifdef MATRIZ_TIMEOUT_EN
    // Down-counter of remaining idle cycles; reloaded on LOAD entry/restart and on every transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt      <= TMO_RELOAD;
            timeout_flag <= 1'b0;
        end else begin
            timeout_flag <= tmo_hit;
            if (clear_frame || transfer) begin
                tmo_cnt <= TMO_RELOAD;
            end else if (state == LOAD && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

    assign elem_ready   = (state == LOAD);
    assign matriz_valid = (state == HOLD);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_matriz_loader.sv
module tb_matriz_loader;

    localparam int MW = 200;

    typedef struct {
        logic [MW-1:0] m;
        logic [1:0]    t;
        logic [4:0]    c;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [1:0]    tamanho_in;
    logic [7:0]    elem_in;
    logic          elem_valid;
    logic          elem_ready;
    logic [MW-1:0] matriz;
    logic [1:0]    tamanho_matriz;
    logic          matriz_valid;
    logic          matriz_ack;
    logic          busy;
    logic [4:0]    elem_count;
    logic          timeout_flag;

    int checks   = 0;
    int failures = 0;

    frame_t     sb_q[$];
    logic [7:0] elems[$];
    frame_t     exp_f;
    logic [MW-1:0] held;
    int pulses;

    matriz_loader #(.ELEM_W(8), .MAX_DIM(5), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .tamanho_in(tamanho_in),
        .elem_in(elem_in), .elem_valid(elem_valid), .elem_ready(elem_ready),
        .matriz(matriz), .tamanho_matriz(tamanho_matriz), .matriz_valid(matriz_valid),
        .matriz_ack(matriz_ack), .busy(busy), .elem_count(elem_count),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_matriz"}, matriz, '0);
        chk({tag, "_tamanho"}, MW'(tamanho_matriz), '0);
        chk({tag, "_valid"}, MW'(matriz_valid), '0);
        chk({tag, "_ready"}, MW'(elem_ready), '0);
        chk({tag, "_busy"}, MW'(busy), '0);
        chk({tag, "_count"}, MW'(elem_count), '0);
        chk({tag, "_tmo"}, MW'(timeout_flag), '0);
    endtask

    task automatic start(input logic [1:0] tam);
        load_start = 1'b1;
        tamanho_in = tam;
        tick();
        load_start = 1'b0;
    endtask

    // Send elems[first..first+n-1]; a wait on elem_ready is bounded.
    task automatic send(input int first, input int n, input bit toggle);
        for (int i = first; i < first + n; i++) begin
            int w = 0;
            while (!elem_ready && w < 20) begin
                tick();
                w++;
            end
            if (!elem_ready) chk("ready_wait_timeout", MW'(elem_ready), MW'(1));
            elem_valid = 1'b1;
            elem_in    = elems[i];
            tick();
            elem_valid = 1'b0;
            if (toggle) tick();
        end
    endtask

    // Expected frame: element k at bits [8*(N-k)-1 -: 8], everything else zero.
    task automatic push_expected(input logic [1:0] tam);
        frame_t f;
        int n;
        n = (tam == 2'b00) ? 4 : (tam == 2'b01) ? 9 : (tam == 2'b10) ? 16 : 25;
        f.m = '0;
        for (int k = 0; k < n; k++) f.m[8*(n-k)-8 +: 8] = elems[k];
        f.t = tam;
        f.c = 5'(n);
        sb_q.push_back(f);
    endtask

    task automatic load_frame(input logic [1:0] tam, input bit toggle, input string tag);
        int n;
        n = elems.size();
        push_expected(tam);
        start(tam);
        send(0, n - 1, toggle);
        chk({tag, "_not_valid_early"}, MW'(matriz_valid), MW'(0));
        chk({tag, "_count_pre"}, MW'(elem_count), MW'(n - 1));
        send(n - 1, 1, 1'b0);
        chk({tag, "_valid"}, MW'(matriz_valid), MW'(1));
        chk({tag, "_ready_low"}, MW'(elem_ready), MW'(0));
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, MW'(0), MW'(1));
        end else begin
            exp_f = sb_q.pop_front();
            chk({tag, "_matriz"}, matriz, exp_f.m);
            chk({tag, "_tamanho"}, MW'(tamanho_matriz), MW'(exp_f.t));
            chk({tag, "_count"}, MW'(elem_count), MW'(exp_f.c));
        end
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; tamanho_in = 2'b00; elem_in = 8'h00;
        elem_valid = 1'b0; matriz_ack = 1'b0;
        tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // 2x2 back-to-back
        elems = '{8'd100, 8'd50, 8'd30, 8'd60};
        load_frame(2'b00, 1'b0, "f2x2");
        chk("f2x2_const", matriz, MW'(32'h6432_1E3C));
        matriz_ack = 1'b1; tick(); matriz_ack = 1'b0;

        // 3x3 with gapped elem_valid, then ack and retention
        elems = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        load_frame(2'b01, 1'b1, "f3x3");
        chk("f3x3_const", matriz, MW'(72'h01_0203_0405_0607_0809));
        held = matriz;
        matriz_ack = 1'b1; tick(); matriz_ack = 1'b0;
        chk("ack_valid_low", MW'(matriz_valid), MW'(0));
        chk("ack_idle", MW'(busy), MW'(0));
        tick();
        chk("ack_retained", matriz, held);
        chk("idle_ready_low", MW'(elem_ready), MW'(0));

        // 5x5 starting with -1; HOLD ignores elements and load_start
        elems.delete();
        elems.push_back(8'hFF);
        for (int v = 1; v <= 24; v++) elems.push_back(8'(v));
        load_frame(2'b11, 1'b0, "f5x5");
        chk("f5x5_msb", MW'(matriz[199:192]), MW'(8'hFF));
        chk("f5x5_lsb", MW'(matriz[7:0]), MW'(8'h18));
        held = matriz;
        elem_valid = 1'b1; elem_in = 8'h55;
        tick(); tick(); tick();
        elem_valid = 1'b0;
        chk("hold_elem_ignored", matriz, held);
        chk("hold_count_frozen", MW'(elem_count), MW'(25));
        start(2'b00);
        chk("hold_start_ignored_valid", MW'(matriz_valid), MW'(1));
        chk("hold_start_ignored_tam", MW'(tamanho_matriz), MW'(2'b11));
        load_start = 1'b1; tamanho_in = 2'b01; matriz_ack = 1'b1;
        tick();
        load_start = 1'b0; matriz_ack = 1'b0;
        chk("ack_start_idle", MW'(busy), MW'(0));
        chk("ack_start_tam", MW'(tamanho_matriz), MW'(2'b11));
        chk("ack_start_retained", matriz, held);

        // Abort mid-3x3, restart as 2x2 with an element offered in the restart cycle
        elems = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14};
        start(2'b01);
        send(0, 5, 1'b0);
        chk("abort_pre_count", MW'(elem_count), MW'(5));
        load_start = 1'b1; tamanho_in = 2'b00; elem_valid = 1'b1; elem_in = 8'h77;
        tick();
        load_start = 1'b0; elem_valid = 1'b0;
        chk("abort_count", MW'(elem_count), MW'(0));
        chk("abort_matriz", matriz, '0);
        chk("abort_tam", MW'(tamanho_matriz), MW'(2'b00));
        chk("abort_busy", MW'(busy), MW'(1));
        elems = '{8'h81, 8'h02, 8'h03, 8'h04};
        push_expected(2'b00);
        send(0, 4, 1'b0);
        chk("abort_valid", MW'(matriz_valid), MW'(1));
        exp_f = sb_q.pop_front();
        chk("abort_matriz_new", matriz, exp_f.m);
        chk("abort_upper_zero", MW'(matriz[199:32]), '0);
        matriz_ack = 1'b1; tick(); matriz_ack = 1'b0;

        // Reset mid-LOAD and in HOLD
        elems = '{8'h11, 8'h22, 8'h33, 8'h44};
        start(2'b10);
        send(0, 2, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset("rst_load");
        elems = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        load_frame(2'b01 ^ 2'b01, 1'b0, "pre_rst_hold");
        rst = 1'b1; load_start = 1'b1; tick(); rst = 1'b0; load_start = 1'b0;
        check_reset("rst_hold");

        // Stall in LOAD after two elements
        elems = '{8'h05, 8'h06};
        start(2'b00);
        send(0, 2, 1'b0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (timeout_flag === 1'b1) pulses++;
        end
`ifdef MATRIZ_TIMEOUT_EN
        chk("tmo_pulses", MW'(pulses), MW'(1));
        chk("tmo_idle", MW'(busy), MW'(0));
        chk("tmo_count", MW'(elem_count), MW'(0));
        chk("tmo_matriz", matriz, '0);
        chk("tmo_valid", MW'(matriz_valid), MW'(0));
`else
        chk("no_tmo_pulses", MW'(pulses), MW'(0));
        chk("no_tmo_busy", MW'(busy), MW'(1));
        chk("no_tmo_ready", MW'(elem_ready), MW'(1));
        chk("no_tmo_count", MW'(elem_count), MW'(2));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matriz_loader.md
Name: matriz_loader

Overview:
Serial-to-packed matrix writer feeding ula_determinante. Accepts signed 8-bit elements one per handshake, row-major, and assembles the packed matriz bus (first element at MSB of used region, unused upper bits zero). Presents matriz plus tamanho_matriz as a stable, valid-flagged frame until the consumer acknowledges it.

Parameters:
ELEM_W, 8, element width in bits (signed)
MAX_DIM, 5, largest supported matrix dimension; matriz width = ELEM_W*MAX_DIM*MAX_DIM = 200
TIMEOUT_CYCLES, 255, idle cycles allowed between elements in LOAD (used only with MATRIZ_TIMEOUT_EN)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous active-high reset
load_start  input  1  begin new frame; samples tamanho_in
tamanho_in  input  2  size code: 00=2x2, 01=3x3, 10=4x4, 11=5x5
elem_in  input  8  signed element, row-major order
elem_valid  input  1  elem_in valid
elem_ready  output  1  loader can accept an element
matriz  output  200  packed signed matrix
tamanho_matriz  output  2  latched size code of current frame
matriz_valid  output  1  frame complete and stable
matriz_ack  input  1  consumer accepted frame
busy  output  1  high in LOAD or HOLD
elem_count  output  5  elements accepted in current frame (0..25)
timeout_flag  output  1  one-cycle pulse on load timeout

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; matriz=0, tamanho_matriz=00, matriz_valid=0, elem_ready=0, busy=0, elem_count=0, timeout_flag=0. Reset wins over every other input, in any state, including mid-frame.
- N (element count) from latched size: 00->4, 01->9, 10->16, 11->25.
- IDLE: elem_ready=0. On load_start: latch tamanho_in into tamanho_matriz, clear matriz and elem_count, go LOAD (elem_ready=1 from next cycle).
- LOAD: elem_ready=1, busy=1. Transfer occurs when elem_valid & elem_ready at clk edge: matriz <= {matriz[191:0], elem_in}; elem_count++. After N transfers, element k (0-based) sits at bits [8*(N-k)-1 : 8*(N-k)-8]; bits above 8*N-1 are zero. On the N-th transfer go HOLD; matriz_valid=1 and elem_ready=0 in the following cycle (1-cycle latency from final transfer to valid).
- load_start while in LOAD: abort and restart — relatch tamanho_in, clear matriz and elem_count, stay LOAD; elem_in in that same cycle is discarded.
- HOLD: matriz, tamanho_matriz, elem_count frozen; matriz_valid=1; elem_ready=0; elem_valid ignored. On matriz_ack: matriz_valid=0 next cycle, go IDLE; matriz retains contents until next load_start.
- load_start in HOLD (with or without matriz_ack same cycle) is ignored; a new frame needs load_start in IDLE.
- matriz_ack outside HOLD has no effect.
- elem_count never exceeds N; no transfer can occur outside LOAD.
- No arithmetic on elements; sign bits passed through unchanged.

Optional Feature:
MATRIZ_TIMEOUT_EN defined: in LOAD a counter resets on each transfer and on entry; if TIMEOUT_CYCLES consecutive cycles pass without a transfer, go IDLE, clear matriz and elem_count, pulse timeout_flag for one cycle; matriz_valid stays 0. Not defined: no counter, LOAD waits indefinitely, timeout_flag tied to 0.

Test Plan:
- Reset then load_start with tamanho_in=00, send 100,50,30,60 back-to-back -> elem_ready drops after 4th, matriz_valid=1 one cycle later, matriz[31:0]=0x64321E3C, matriz[199:32]=0, tamanho_matriz=00, elem_count=4.
- tamanho_in=01, send 1..9 with elem_valid toggling every other cycle -> matriz[71:0]={01,02,...,09}, upper bits 0, valid only after 9th transfer; ack -> matriz_valid=0 next cycle, state IDLE, matriz retained.
- tamanho_in=11, send -1 then 24 values 1..24 -> matriz[199:192]=0xFF, matriz[7:0]=0x18, elem_count=25; elem_valid held high in HOLD causes no change.
- Abort: 3x3 frame, after 5 elements assert load_start with tamanho_in=00 -> elem_count=0, 4 new elements yield a clean 2x2 frame, no residue above bit 31.
- rst asserted mid-LOAD after 2 elements and while in HOLD -> all outputs return to reset values next edge; load_start in HOLD without reset is ignored.
- With MATRIZ_TIMEOUT_EN, TIMEOUT_CYCLES=8: 2 elements then idle 8 cycles -> timeout_flag single pulse, state IDLE, elem_count=0; without the macro same stimulus stays in LOAD, timeout_flag=0.
